div_unit: RTL and testbench

// - Multi-cycle radix-2 restoring divider for DIV/DIVU, sitting beside the EX stage.
// - EX issues operands plus start_i, then raises stallreq_from_ex until ready_o is high.
// - On completion, EX forwards {remainder, quotient} as {hi, lo} through whilo_o to EX/MEM.

---
 rtl/div_unit.sv | 131 +++++++++++++
 tb/tb_div_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage; result is {remainder, quotient}.
// Optional macro DIV_ZERO_FLAG_EN adds the div_zero_o output flag.
module div_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic                  div_zero_o
`endif
);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   divisor;
    logic                neg_quo;
    logic                neg_rem;

    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     diff;
    logic                fits;
    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic [DATA_W-1:0]   fixed_rem;
    logic [DATA_W-1:0]   fixed_quo;

    // quo starts as the dividend magnitude; its MSB feeds the remainder while quotient bits fill from the LSB
    always_comb begin
        shifted   = {rem, quo[DATA_W-1]};
        diff      = shifted - {1'b0, divisor};
        fits      = (shifted >= {1'b0, divisor});
        mag1      = (signed_div_i && opdata1_i[DATA_W-1]) ? ('0 - opdata1_i) : opdata1_i;
        mag2      = (signed_div_i && opdata2_i[DATA_W-1]) ? ('0 - opdata2_i) : opdata2_i;
        fixed_rem = neg_rem ? ('0 - rem) : rem;
        fixed_quo = neg_quo ? ('0 - quo) : quo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FREE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b0;
`endif
        end else begin
            case (state)
                S_FREE: begin
                    if (start_i && !annul_i) begin
                        neg_rem <= signed_div_i & opdata1_i[DATA_W-1];
                        neg_quo <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        cnt     <= '0;
                        if (opdata2_i == '0) begin
                            state <= S_BYZERO;
                        end else begin
                            state   <= S_ON;
                            rem     <= '0;
                            quo     <= mag1;
                            divisor <= mag2;
                        end
                    end
                end

                S_BYZERO: begin
                    state    <= S_END;
                    result_o <= '0;
                    ready_o  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_o <= 1'b1;
`endif
                end

                S_ON: begin
                    if (annul_i) begin
                        state    <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (cnt != LAST_STEP) begin
                        rem <= fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], fits};
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        state    <= S_END;
                        result_o <= {fixed_rem, fixed_quo};
                        ready_o  <= 1'b1;
                    end
                end

                S_END: begin
                    if (!start_i) begin
                        state    <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_o <= 1'b0;
`endif
                    end
                end

                default: state <= S_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected {rem, quo} and due cycle, monitor checks on ready_o rise.
// Builds with or without DIV_ZERO_FLAG_EN.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdiv;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero;
`endif

    always #5 clk = ~clk;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sdiv),
        .opdata1_i    (a),
        .opdata2_i    (b),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero_o   (div_zero)
`endif
    );

    typedef struct {
        logic [63:0] res;
        int unsigned due;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int unsigned cycle = 0;
    int          checks = 0;
    int          fails = 0;
    logic        ready_q = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Plain-arithmetic reference: truncating division on sign- or zero-extended 64-bit values
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x, input logic [31:0] y);
        longint nx, ny, q, r;
        if (y == 32'd0) return 64'd0;
        if (s) begin
            nx = longint'($signed(x));
            ny = longint'($signed(y));
        end else begin
            nx = longint'({32'd0, x});
            ny = longint'({32'd0, y});
        end
        q = nx / ny;
        r = nx % ny;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ready === 1'b1 && ready_q !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_ready: got ready_o=1 expected 0 (cycle %0d)", cycle);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("latency", 64'(cycle), 64'(e.due));
`ifdef DIV_ZERO_FLAG_EN
                check("div_zero", 64'(div_zero), 64'(e.dz));
`endif
            end
        end
        ready_q = ready;
    end

    // mode 0: complete op; mode 1: annul after abort_cyc cycles; mode 2: reset after abort_cyc cycles
    task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                          input int mode, input int abort_cyc);
        logic [63:0] exp;
        int unsigned lat;
        bit          got;
        exp = ref_div(s, x, y);
        // accept edge E0 is the next posedge; zero divisor: BYZERO then END one edge later
        lat = (y == 32'd0) ? 1 : 33;
        sdiv  = s;
        a     = x;
        b     = y;
        start = 1'b1;
        if (mode == 0) sb.push_back('{exp, cycle + 1 + lat, (y == 32'd0)});
        @(negedge clk);
        a    = $urandom;
        b    = $urandom;
        sdiv = 1'($urandom_range(0, 1));
        if (mode != 0) begin
            repeat (abort_cyc - 1) @(negedge clk);
            start = 1'b0;
            if (mode == 1) annul = 1'b1;
            else           rst   = 1'b1;
            @(negedge clk);
            check(mode == 1 ? "annul_ready" : "rst_ready", 64'(ready), 64'd0);
            check(mode == 1 ? "annul_result" : "rst_result", result, 64'd0);
            annul = 1'b0;
            rst   = 1'b0;
            return;
        end
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (ready === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL timeout: got ready_o=0 expected 1 within 60 cycles (cycle %0d)", cycle);
            sb.delete();
            start = 1'b0;
            rst   = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("hold_ready", 64'(ready), 64'd1);
            check("hold_result", result, exp);
        end
        start = 1'b0;
        @(negedge clk);
        check("release_ready", 64'(ready), 64'd0);
        check("release_result", result, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("release_div_zero", 64'(div_zero), 64'd0);
`endif
    endtask

    initial begin
        logic        s;
        logic [31:0] x;
        logic [31:0] y;
        rst   = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        sdiv  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("reset_div_zero", 64'(div_zero), 64'd0);
`endif
        rst = 1'b0;

        run_op(1'b0, 32'd100, 32'd7, 0, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'h2, 0, 0);
        run_op(1'b1, 32'h7, 32'hFFFF_FFFE, 0, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(1'b0, 32'd5, 32'd0, 0, 0);
        run_op(1'b1, 32'hFFFF_FFF0, 32'd0, 0, 0);

        run_op(1'b0, 32'hFFFF_FFFF, 32'd3, 1, 10);
        repeat (40) @(negedge clk);
        check("annul_stays_idle", 64'(ready), 64'd0);
        run_op(1'b0, 32'd9, 32'd3, 0, 0);

        run_op(1'b1, 32'h1234_5678, 32'h0000_0321, 2, 15);
        run_op(1'b0, 32'hDEAD_BEEF, 32'h0000_1000, 0, 0);

        for (int n = 0; n < 40; n++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       x = 32'h8000_0000;
                1:       x = $urandom_range(0, 255);
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       y = 32'd0;
                1:       y = 32'hFFFF_FFFF;
                2:       y = $urandom_range(1, 15);
                3:       y = 32'h8000_0000;
                default: y = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(s, x, y, 0, 0);
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected $finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
